// File: rtl/seg_scan.sv
// Two-digit multiplexed 7-segment scanner: drives the digit-mux select and lights one anode at a time, with a blanking gap between digits.
// Latency: every output is registered; seg shows decode(y) one cycle after y is sampled, and s changes on the edge that enters a BLANK state.
// Backpressure: none. en low sends the scanner to IDLE on the next edge (all anodes off), and rst overrides en and every state.
// Ports: clk, rst (sync, active-high), en (scan enable), y (digit from upstream mux),
//        s (mux select), seg ({g..a}, active-low), an (anodes, active-low, an[0]=A), frame (end-of-scan pulse).
module seg_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] y,
  output logic       s,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int MAXLEN = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK_A,
    ST_SHOW_A,
    ST_BLANK_B,
    ST_SHOW_B
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_q, frame_d;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    s_d     = s_q;
    an_d    = 2'b11;
    seg_d   = 7'h7F;
    frame_d = 1'b0;

    case (state_q)
      ST_IDLE:    if (en) state_d = ST_BLANK_A;
      ST_BLANK_A: if (cnt_q == BLANK_LAST) state_d = ST_SHOW_A;
      ST_SHOW_A:  if (cnt_q == DIV_LAST) state_d = ST_BLANK_B;
      ST_BLANK_B: if (cnt_q == BLANK_LAST) state_d = ST_SHOW_B;
      ST_SHOW_B:  if (cnt_q == DIV_LAST) state_d = ST_BLANK_A;
      default:    state_d = ST_IDLE;
    endcase

    if (!en) state_d = ST_IDLE;

    // Counter restarts on every state entry; IDLE keeps it parked at zero.
    if (state_d != state_q || state_d == ST_IDLE) cnt_d = '0;

    // Outputs are registered from the state being entered, so they line up
    // with state_q after the edge.
    case (state_d)
      ST_BLANK_A: s_d = 1'b0;
      ST_SHOW_A: begin
        s_d  = 1'b0;
        an_d = 2'b10;
      end
      ST_BLANK_B: s_d = 1'b1;
      ST_SHOW_B: begin
        s_d     = 1'b1;
        an_d    = 2'b01;
        frame_d = (cnt_d == DIV_LAST);
      end
      default: ;
    endcase

    // y reflects s_q (already settled for the upcoming digit, since every
    // SHOW is preceded by at least one BLANK cycle).
    if (state_d != ST_IDLE) seg_d = hex2seg(y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 2'b11;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign s     = s_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance: DIV=4, BLANK=2
  logic       rst_m, en_m, s_m, frame_m;
  logic [3:0] a_m, b_m, y_m;
  logic [6:0] seg_m;
  logic [1:0] an_m;
  assign y_m = s_m ? b_m : a_m;

  // Decode-sweep instance: long SHOW
  logic       rst_o, en_s, s_s, frame_s;
  logic [3:0] a_s, b_s, y_s;
  logic [6:0] seg_s;
  logic [1:0] an_s;
  assign y_s = s_s ? b_s : a_s;

  // Minimum-parameter instance: DIV=1, BLANK=1
  logic       en_n, s_n, frame_n;
  logic [3:0] a_n, b_n, y_n;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  assign y_n = s_n ? b_n : a_n;

  seg_scan #(.DIV(4), .BLANK(2)) u_main (
    .clk(clk), .rst(rst_m), .en(en_m), .y(y_m),
    .s(s_m), .seg(seg_m), .an(an_m), .frame(frame_m)
  );

  seg_scan #(.DIV(100), .BLANK(2)) u_sweep (
    .clk(clk), .rst(rst_o), .en(en_s), .y(y_s),
    .s(s_s), .seg(seg_s), .an(an_s), .frame(frame_s)
  );

  seg_scan #(.DIV(1), .BLANK(1)) u_min (
    .clk(clk), .rst(rst_o), .en(en_n), .y(y_n),
    .s(s_n), .seg(seg_n), .an(an_n), .frame(frame_n)
  );

  logic [6:0] seg_tbl [0:15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_m(input string tag);
    chk({tag, "/s"}, {31'd0, s_m}, 32'd0);
    chk({tag, "/an"}, {30'd0, an_m}, 32'h3);
    chk({tag, "/seg"}, {25'd0, seg_m}, 32'h7F);
    chk({tag, "/frame"}, {31'd0, frame_m}, 32'd0);
  endtask

  // p = position within the 12-cycle scan, 0 = first cycle of BLANK_A.
  task automatic chk_main(input int p, input string tag);
    logic [1:0] e_an;
    e_an = (p < 2) ? 2'b11 : (p < 6) ? 2'b10 : (p < 8) ? 2'b11 : 2'b01;
    chk({tag, "/an"}, {30'd0, an_m}, {30'd0, e_an});
    chk({tag, "/s"}, {31'd0, s_m}, (p >= 6) ? 32'd1 : 32'd0);
    chk({tag, "/frame"}, {31'd0, frame_m}, (p == 11) ? 32'd1 : 32'd0);
    if (e_an != 2'b11)
      chk({tag, "/seg"}, {25'd0, seg_m}, (p < 8) ? 32'h30 : 32'h46);
  endtask

  initial begin
    seg_tbl[0]  = 7'h40; seg_tbl[1]  = 7'h79; seg_tbl[2]  = 7'h24; seg_tbl[3]  = 7'h30;
    seg_tbl[4]  = 7'h19; seg_tbl[5]  = 7'h12; seg_tbl[6]  = 7'h02; seg_tbl[7]  = 7'h78;
    seg_tbl[8]  = 7'h00; seg_tbl[9]  = 7'h10; seg_tbl[10] = 7'h08; seg_tbl[11] = 7'h03;
    seg_tbl[12] = 7'h46; seg_tbl[13] = 7'h21; seg_tbl[14] = 7'h06; seg_tbl[15] = 7'h0E;

    rst_m = 1'b1; en_m = 1'b1; a_m = 4'h3; b_m = 4'hC;
    rst_o = 1'b1; en_s = 1'b0; a_s = 4'h0; b_s = 4'h0;
    en_n = 1'b0; a_n = 4'h5; b_n = 4'hE;

    // Reset held 3 cycles with en=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_m("reset");
    end
    rst_m = 1'b0;
    rst_o = 1'b0;

    // Steady scan, two full periods plus part of a third
    for (int i = 0; i < 34; i++) begin
      tick();
      chk_main(i % 12, "scan");
    end

    // Now in SHOW_B cycle 2: drop en
    en_m = 1'b0;
    tick();
    chk("dis/an", {30'd0, an_m}, 32'h3);
    chk("dis/seg", {25'd0, seg_m}, 32'h7F);
    chk("dis/frame", {31'd0, frame_m}, 32'd0);
    chk("dis/s_hold", {31'd0, s_m}, 32'd1);
    tick();
    chk("dis2/frame", {31'd0, frame_m}, 32'd0);
    chk("dis2/an", {30'd0, an_m}, 32'h3);

    // Re-enable: restart from BLANK_A, run into BLANK_B
    en_m = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_main(i, "restart");
    end

    // Reset during BLANK_B with en still high
    rst_m = 1'b1;
    tick();
    chk_reset_m("midrst");
    tick();
    chk_reset_m("midrst2");
    rst_m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_main(i, "postrst");
    end

    // Decode sweep while parked in SHOW_A
    en_s = 1'b1;
    repeat (3) tick();
    chk("sweep/an", {30'd0, an_s}, 32'h2);
    for (int v = 0; v < 16; v++) begin
      a_s = 4'(v);
      tick();
      chk($sformatf("sweep/seg%0h", v), {25'd0, seg_s}, {25'd0, seg_tbl[v]});
    end
    chk("sweep/an_end", {30'd0, an_s}, 32'h2);

    // Minimum parameters: 4-cycle period
    en_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int p;
      p = i % 4;
      tick();
      chk($sformatf("min%0d/an", i), {30'd0, an_n},
          (p == 0 || p == 2) ? 32'h3 : (p == 1) ? 32'h2 : 32'h1);
      chk($sformatf("min%0d/frame", i), {31'd0, frame_n}, (p == 3) ? 32'd1 : 32'd0);
      if (p == 1) chk($sformatf("min%0d/segA", i), {25'd0, seg_n}, 32'h12);
      if (p == 3) chk($sformatf("min%0d/segB", i), {25'd0, seg_n}, 32'h06);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
